// File: rtl/gaussian_blur_3x3.sv
// 3x3 Gaussian blur on a raster grayscale stream, two line buffers deep.
// Border pixels pass the centre value through unfiltered.
module gaussian_blur_3x3 #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_last
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t state, state_nx;

    logic          en;
    logic [CW-1:0] icol, ocol;
    logic [RW-1:0] irow, orow;

    logic [7:0] lb0 [WIDTH];
    logic [7:0] lb1 [WIDTH];
    logic [7:0] win [3][3];

    logic       out_free, accept, fl_emit, shift, emit;
    logic       in_last, frame_done, border, is_last_out;
    logic [7:0] pix, nc0, nc1, pix_out;
    logic [11:0] sum, rounded;

    assign out_free  = ~dout_valid | dout_ready;
    assign din_ready = en & (state != FLUSH) & out_free;
    assign accept    = din_valid & din_ready;
    assign fl_emit   = (state == FLUSH) & out_free & ~(dout_valid & dout_last);
    assign shift     = accept | fl_emit;
    assign emit      = (accept & (state == RUN)) | fl_emit;

    assign in_last    = (irow == ROW_LAST) & (icol == COL_LAST);
    assign frame_done = (state == FLUSH) & dout_valid & dout_last & dout_ready;

    // Flush shifts in dummy zeros; every flushed output is a border pixel.
    assign pix = (state == FLUSH) ? 8'd0 : din;
    assign nc0 = lb1[icol];
    assign nc1 = lb0[icol];

    always_comb begin
        sum = 12'(win[0][1])        + (12'(win[0][2]) << 1) + 12'(nc0)
            + (12'(win[1][1]) << 1) + (12'(win[1][2]) << 2) + (12'(nc1) << 1)
            + 12'(win[2][1])        + (12'(win[2][2]) << 1) + 12'(pix);
        rounded = sum + 12'd8;
    end

    assign border = (orow == '0) | (orow == ROW_LAST)
                  | (ocol == '0) | (ocol == COL_LAST);
    assign is_last_out = (orow == ROW_LAST) & (ocol == COL_LAST);
    assign pix_out = border ? win[1][2] : rounded[11:4];

    always_ff @(posedge clock) begin
        if (shift) begin
            lb0[icol] <= pix;
            lb1[icol] <= lb0[icol];
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= nc0;
            win[1][2] <= nc1;
            win[2][2] <= pix;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FILL;
            en    <= 1'b0;
        end else begin
            state <= state_nx;
            en    <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:    if (accept && irow == RW'(1) && icol == '0) state_nx = RUN;
            RUN:     if (accept && in_last) state_nx = FLUSH;
            FLUSH:   if (frame_done) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icol <= '0;
            irow <= '0;
        end else if (frame_done) begin
            icol <= '0;
            irow <= '0;
        end else if (shift) begin
            if (icol == COL_LAST) begin
                icol <= '0;
                irow <= (irow == ROW_LAST) ? '0 : irow + RW'(1);
            end else begin
                icol <= icol + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            ocol       <= '0;
            orow       <= '0;
        end else if (emit) begin
            dout       <= pix_out;
            dout_valid <= 1'b1;
            dout_last  <= is_last_out;
            if (ocol == COL_LAST) begin
                ocol <= '0;
                orow <= (orow == ROW_LAST) ? '0 : orow + RW'(1);
            end else begin
                ocol <= ocol + CW'(1);
            end
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end
    end

endmodule

// File: doc/gaussian_blur_3x3.md
GAUSSIAN_BLUR_3X3 -- requirements
Module: gaussian_blur_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 400, meaning pixels per line (the downsampled 800x600 frame).
REQ-002 SHALL have parameter HEIGHT, default 300, meaning lines per frame.
REQ-003 SHALL have port clock  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port din  input  8  grayscale input pixel, raster order.
REQ-006 SHALL have port din_valid  input  1  din holds a pixel.
REQ-007 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port dout  output  8  filtered pixel, raster order.
REQ-009 SHALL have port dout_valid  output  1  dout holds a pixel.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 SHALL have port dout_last  output  1  dout is pixel N-1 of the frame (N = WIDTH*HEIGHT).

Function
REQ-012 Transfer rules: input accepted iff din_valid & din_ready; output consumed iff dout_valid & dout_ready.
REQ-013 Kernel [1 2 1; 2 4 2; 1 2 1]; dout = (weighted 12-bit sum + 8) >> 4; no saturation needed (max 4088 >> 4 = 255).
REQ-014 Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) SHALL output the unfiltered centre pixel.
REQ-015 Storage: two WIDTH x 8 line buffers plus a 3x3 window register array; no frame buffer.
REQ-016 Exactly one output per input pixel, same raster order; N outputs per frame.
REQ-017 Output k (raster index) becomes valid on the cycle after input k+WIDTH+1 is accepted, for k < N-WIDTH-1.
REQ-018 Outputs k = N-WIDTH-1 .. N-1 (WIDTH+1 pixels) are produced in state FLUSH without further input.
REQ-019 States: FILL (first WIDTH+1 inputs, no output), RUN (one output per accepted input), FLUSH (emit WIDTH+1 outputs).
REQ-020 FILL->RUN on acceptance of input WIDTH (0-based); RUN->FLUSH on acceptance of input N-1; FLUSH->FILL when output N-1 is consumed.
REQ-021 din_ready = (state != FLUSH) & (~dout_valid | dout_ready).
REQ-022 In FLUSH, a new output is loaded each cycle the output register is empty or being consumed.
REQ-023 dout, dout_valid, dout_last SHALL hold stable while dout_valid & ~dout_ready.
REQ-024 dout_last = 1 only with output N-1; next frame's input 0 is acceptable the cycle after that consumption.
REQ-025 Input and output column/row counters wrap at WIDTH-1 / HEIGHT-1; no data lost or duplicated across line or frame boundaries.
REQ-026 din_valid low for any number of cycles SHALL not alter state or outputs.

Reset
REQ-027 reset asserted (any cycle, including mid-frame or mid-FLUSH): dout_valid=0, dout_last=0, dout=0, din_ready=0, state=FILL, all counters=0, immediately and asynchronously.
REQ-028 Line-buffer contents need not be cleared; first frame after reset SHALL be correct regardless.
REQ-029 din_ready rises the first clock edge after reset deasserts.

Verification (WIDTH=4, HEIGHT=4 unless stated)
REQ-030 Constant frame, all din=100, dout_ready=1 -> 16 outputs all 100, dout_last only on 16th, first dout_valid one cycle after 6th input accepted.
REQ-031 Impulse: din=160 at (1,1), 0 elsewhere -> dout(1,1)=40, (1,2)=20, (2,1)=20, (2,2)=10, all border outputs 0.
REQ-032 All din=255 -> every output 255 (rounding/overflow check).
REQ-033 Backpressure: dout_ready=0 for 5 cycles mid-RUN -> dout held constant, din_ready=0, full output sequence identical to REQ-030 reference.
REQ-034 Flush: after input 15 accepted -> din_ready=0, exactly 5 further outputs (k=11..15), dout_last on k=15, then din_ready=1 and a second frame filters correctly.
REQ-035 Reset after input 9 of a frame -> outputs cleared at once; a following full frame of 100s yields 16 outputs of 100.
